// File: rtl/event_capture_fifo_pkg.sv
// ----------------------------------------------------------------------------
// event_capture_fifo_pkg
//   Shared definitions for the event capture FIFO.
//   - Default widths/depth used as parameter defaults by the top and the FIFO.
//   - Helper functions that describe the layout of one stored entry:
//       entry = { timestamp[TS_W-1:0], in_1bit, in_8bit[DATA_W-1:0] }
//     The data bus sits at the bottom, the single bit directly above it, and
//     the timestamp occupies the top TS_W bits.
// ----------------------------------------------------------------------------
package event_capture_fifo_pkg;

    localparam int DEFAULT_DATA_W     = 8;
    localparam int DEFAULT_TS_W       = 16;
    localparam int DEFAULT_DEPTH_LOG2 = 4;

    // Total width of one FIFO entry.
    function automatic int entry_w(input int ts_w, input int data_w);
        return ts_w + 1 + data_w;
    endfunction

    // LSB of the data-bus field inside an entry.
    function automatic int data_lsb(input int data_w);
        return (data_w > 0) ? 0 : 0;
    endfunction

    // Position of the single-bit field inside an entry.
    function automatic int bit_pos(input int data_w);
        return data_w;
    endfunction

    // LSB of the timestamp field inside an entry.
    function automatic int ts_lsb(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/event_capture_fifo_sync_fifo_sa.sv
// ----------------------------------------------------------------------------
// sync_fifo_sa
//   Show-ahead synchronous FIFO. The head entry is presented combinationally
//   whenever the FIFO is not empty, so a consumer sees data in the same cycle
//   that it becomes available and pops it with a single-cycle strobe.
//
// Ports
//   clk        in   1              clock, rising edge
//   rst        in   1              asynchronous active-high reset (pointers only)
//   push       in   1              write request
//   push_data  in   WIDTH          data written on push
//   pop        in   1              read request; ignored while empty
//   head       out  WIDTH          head entry, forced to 0 while empty
//   empty      out  1              no entries stored
//   full       out  1              2**DEPTH_LOG2 entries stored
//   level      out  DEPTH_LOG2+1   number of entries stored
//
// A push while full is accepted only if a pop happens in the same cycle; the
// caller is responsible for any bookkeeping of rejected pushes.
// ----------------------------------------------------------------------------
module sync_fifo_sa
    import event_capture_fifo_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [WIDTH-1:0]      push_data,
    input  logic                  pop,
    output logic [WIDTH-1:0]      head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    // Storage is intentionally not reset; the head is masked while empty.
    logic [WIDTH-1:0]    mem [DEPTH];

    // One extra MSB distinguishes full from empty when the addresses match.
    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic                do_pop;
    logic                do_push;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                     (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign level   = wr_ptr - rd_ptr;

    assign do_pop  = pop & ~empty;
    // When full, a simultaneous pop frees the slot being written, so the
    // write lands in the slot the head is leaving.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + (DEPTH_LOG2+1)'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + (DEPTH_LOG2+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_data;
        end
    end

    // Show-ahead: the head is read asynchronously so it is valid in the
    // cycle right after the write.
    assign head = empty ? '0 : mem[rd_ptr[DEPTH_LOG2-1:0]];

endmodule

// File: rtl/event_capture_fifo.sv
// ----------------------------------------------------------------------------
// event_capture_fifo
//   Samples a 1-bit line and a DATA_W-bit bus, detects every change of the
//   combined value and records {timestamp, in_1bit, in_8bit} in a show-ahead
//   FIFO that readout logic drains with rd_en.
//
// Ports
//   clk           in   1             clock, rising edge
//   rst           in   1             asynchronous active-high reset
//   in_1bit       in   1             monitored single-bit line (clk-synchronous)
//   in_8bit       in   DATA_W        monitored bus (clk-synchronous)
//   rd_en         in   1             pop request, honoured only when rd_valid
//   clr_overflow  in   1             clears the sticky overflow flag
//   rd_valid      out  1             head entry present
//   rd_timestamp  out  TS_W          head entry timestamp
//   rd_data_1bit  out  1             head entry in_1bit value
//   rd_data_8bit  out  DATA_W        head entry in_8bit value
//   fill_level    out  DEPTH_LOG2+1  number of stored entries
//   full          out  1             FIFO holds 2**DEPTH_LOG2 entries
//   overflow      out  1             sticky: an event was dropped while full
//
// Timing: a value sampled into s1 at edge k raises the event in the following
// cycle, and the entry is written at edge k+1 carrying the timestamp value
// ts_cnt had after edge k (which equals k edges after reset release).
// ----------------------------------------------------------------------------
module event_capture_fifo
    import event_capture_fifo_pkg::*;
#(
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int TS_W       = DEFAULT_TS_W,
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_1bit,
    input  logic [DATA_W-1:0]     in_8bit,
    input  logic                  rd_en,
    input  logic                  clr_overflow,
    output logic                  rd_valid,
    output logic [TS_W-1:0]       rd_timestamp,
    output logic                  rd_data_1bit,
    output logic [DATA_W-1:0]     rd_data_8bit,
    output logic [DEPTH_LOG2:0]   fill_level,
    output logic                  full,
    output logic                  overflow
);

    localparam int ENTRY_W  = entry_w(TS_W, DATA_W);
    localparam int DATA_LSB = data_lsb(DATA_W);
    localparam int BIT_POS  = bit_pos(DATA_W);
    localparam int TS_LSB   = ts_lsb(DATA_W);

    logic [TS_W-1:0]    ts_cnt;
    logic [DATA_W:0]    s1;
    logic [DATA_W:0]    s2;
    logic               warm;
    logic               primed;
    logic               capture_event;
    logic               drop;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;

    // Sampler and timestamp. s2 only holds a real sample after the second
    // edge following reset release, so primed trails the first sample by one
    // edge: the very first sample acts as the baseline and is never compared
    // against the reset value of s2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt <= '0;
            s1     <= '0;
            s2     <= '0;
            warm   <= 1'b0;
            primed <= 1'b0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            s1     <= {in_1bit, in_8bit};
            s2     <= s1;
            warm   <= 1'b1;
            primed <= warm;
        end
    end

    assign capture_event = primed & (s1 != s2);
    assign wr_entry      = {ts_cnt, s1};

    // An event is lost only when the FIFO is full and no pop frees a slot
    // in the same cycle.
    assign drop = capture_event & fifo_full & ~(rd_en & ~fifo_empty);

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    sync_fifo_sa #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (capture_event),
        .push_data  (wr_entry),
        .pop        (rd_en),
        .head       (head_entry),
        .empty      (fifo_empty),
        .full       (fifo_full),
        .level      (fill_level)
    );

    assign rd_valid     = ~fifo_empty;
    assign full         = fifo_full;
    assign rd_timestamp = head_entry[TS_LSB +: TS_W];
    assign rd_data_1bit = head_entry[BIT_POS];
    assign rd_data_8bit = head_entry[DATA_LSB +: DATA_W];

endmodule
